// File: rtl/placar_controlador.sv
// rtl/placar_controlador.sv - debounced button sequencer, saturating 0..99 score and digit scan
module placar_controlador #(
    parameter int DEB_CYCLES = 4,
    parameter int SCAN_DIV   = 16,
    parameter int MAX_SCORE  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn,
    input  logic       sinal,
    input  logic       ch,
    output logic [6:0] pontos,
    output logic       upd,
    output logic       alerta,
    output logic [1:0] sclk,
    output logic       dig_sel
);

    localparam int CNT_W  = $clog2(DEB_CYCLES + 1);
    localparam int SCAN_W = $clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0]  DEB_MAX   = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic signed [7:0] MAX_S     = 8'(MAX_SCORE);
    localparam logic [6:0]        MAX_P     = 7'(MAX_SCORE);
    localparam logic [6:0]        FORCED    = 7'd99;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        APPLY,
        WAIT_RELEASE
    } state_t;

    state_t            state;
    logic [1:0]        code;
    logic [1:0]        lcode;
    logic [CNT_W-1:0]  cnt;
    logic [SCAN_W-1:0] scnt;
    logic signed [7:0] raw;

    // Highest-valued button wins when several are held together.
    always_comb begin
        code = 2'd0;
        if (btn[2]) begin
            code = 2'd3;
        end else if (btn[1]) begin
            code = 2'd2;
        end else if (btn[0]) begin
            code = 2'd1;
        end
    end

    always_comb begin
        raw = 8'sd0;
        if (sinal) begin
            raw = $signed({1'b0, pontos}) - $signed({6'b0, lcode});
        end else begin
            raw = $signed({1'b0, pontos}) + $signed({6'b0, lcode});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            lcode  <= 2'd0;
            cnt    <= '0;
            pontos <= 7'd0;
            upd    <= 1'b0;
            alerta <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (code != 2'd0) begin
                        lcode <= code;
                        cnt   <= CNT_W'(1);
                        state <= (DEB_CYCLES == 1) ? APPLY : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (code == 2'd0) begin
                        state <= IDLE;
                    end else if (code != lcode) begin
                        lcode <= code;
                        cnt   <= CNT_W'(1);
                    end else if (cnt == DEB_MAX) begin
                        state <= APPLY;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                APPLY: begin
                    if (raw > MAX_S) begin
                        pontos <= MAX_P;
                        alerta <= 1'b1;
                    end else if (raw < 8'sd0) begin
                        pontos <= 7'd0;
                        alerta <= 1'b1;
                    end else begin
                        pontos <= raw[6:0];
                        alerta <= 1'b0;
                    end
                    upd   <= 1'b1;
                    cnt   <= '0;
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    // Any press while waiting restarts the release window.
                    if (code != 2'd0) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            // The override wins over any write made by APPLY in the same cycle.
            if (ch) begin
                pontos <= FORCED;
                alerta <= 1'b0;
                upd    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt    <= '0;
            dig_sel <= 1'b0;
            sclk    <= 2'b01;
        end else if (scnt == SCAN_LAST) begin
            scnt    <= '0;
            dig_sel <= ~dig_sel;
            sclk    <= dig_sel ? 2'b01 : 2'b10;
        end else begin
            scnt <= scnt + SCAN_W'(1);
        end
    end

endmodule

// File: tb/tb_placar_controlador.sv
// tb/tb_placar_controlador.sv - directed and randomized checks of placar_controlador against a press-level model
module tb_placar_controlador;

    localparam int DEB  = 4;
    localparam int SCAN = 16;

    logic       clk;
    logic       rst;
    logic [2:0] btn;
    logic       sinal;
    logic       ch;
    logic [6:0] pontos;
    logic       upd;
    logic       alerta;
    logic [1:0] sclk;
    logic       dig_sel;

    int n_assert;
    int n_fail;

    // Model state: run length of the current nonzero code while armed,
    // a pending apply, and a zero-run while waiting for release.
    int m_pontos;
    int m_alerta;
    int m_upd;
    int m_edges;
    int m_run;
    int m_rcode;
    int m_pend;
    int m_pcode;
    int m_wait;
    int m_zrun;

    placar_controlador #(
        .DEB_CYCLES(DEB),
        .SCAN_DIV  (SCAN),
        .MAX_SCORE (99)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .sinal  (sinal),
        .ch     (ch),
        .pontos (pontos),
        .upd    (upd),
        .alerta (alerta),
        .sclk   (sclk),
        .dig_sel(dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pontos = 0;
        m_alerta = 0;
        m_upd    = 0;
        m_edges  = 0;
        m_run    = 0;
        m_rcode  = 0;
        m_pend   = 0;
        m_pcode  = 0;
        m_wait   = 0;
        m_zrun   = 0;
    endtask

    task automatic model_step();
        int c;
        int r;
        c = btn[2] ? 3 : (btn[1] ? 2 : (btn[0] ? 1 : 0));
        m_upd = 0;
        if (m_pend != 0) begin
            m_pend = 0;
            m_wait = 1;
            m_zrun = 0;
            r = sinal ? m_pontos - m_pcode : m_pontos + m_pcode;
            if (r > 99) begin
                m_pontos = 99;
                m_alerta = 1;
            end else if (r < 0) begin
                m_pontos = 0;
                m_alerta = 1;
            end else begin
                m_pontos = r;
                m_alerta = 0;
            end
            m_upd = 1;
        end else if (m_wait != 0) begin
            m_zrun = (c == 0) ? m_zrun + 1 : 0;
            if (m_zrun == DEB) begin
                m_wait = 0;
                m_run  = 0;
            end
        end else begin
            if (c == 0) begin
                m_run = 0;
            end else if (m_run > 0 && c == m_rcode) begin
                m_run++;
            end else begin
                m_rcode = c;
                m_run   = 1;
            end
            if (m_run == DEB + 1) begin
                m_pend  = 1;
                m_pcode = m_rcode;
            end
        end
        if (ch) begin
            m_pontos = 99;
            m_alerta = 0;
            m_upd    = 0;
        end
        m_edges++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("pontos", pontos, m_pontos);
        chk("upd", upd, m_upd);
        chk("alerta", alerta, m_alerta);
        chk("sclk", sclk, ((m_edges / SCAN) % 2 == 1) ? 2 : 1);
        chk("dig_sel", dig_sel, (m_edges / SCAN) % 2);
    endtask

    // Called just after a falling edge; reset asserts and checks before any rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_pontos", pontos, 0);
        chk("rst_upd", upd, 0);
        chk("rst_alerta", alerta, 0);
        chk("rst_sclk", sclk, 1);
        chk("rst_dig_sel", dig_sel, 0);
        #1;
        rst = 1'b0;
    endtask

    task automatic press(input logic [2:0] b, input logic s, input int hold, input int rel,
                         output int nupd);
        nupd  = 0;
        btn   = b;
        sinal = s;
        repeat (hold) begin
            tick();
            if (upd === 1'b1) nupd++;
        end
        btn = 3'b000;
        repeat (rel) begin
            tick();
            if (upd === 1'b1) nupd++;
        end
    endtask

    initial begin
        int nupd;
        int guard;
        n_assert = 0;
        n_fail   = 0;
        rst   = 1'b1;
        btn   = 3'b000;
        sinal = 1'b0;
        ch    = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Two-point press from reset: score appears on the sixth edge.
        nupd  = 0;
        btn   = 3'b010;
        sinal = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (upd === 1'b1) nupd++;
            if (i == 5) chk("lat_before", pontos, 0);
            if (i == 6) begin
                chk("lat_pontos", pontos, 2);
                chk("lat_upd", upd, 1);
            end
            if (i == 7) chk("lat_upd_off", upd, 0);
        end
        btn = 3'b000;
        repeat (6) tick();
        chk("one_update", nupd, 1);
        chk("press_alerta", alerta, 0);

        // Short glitch is rejected.
        press(3'b001, 1'b0, 3, 8, nupd);
        chk("glitch_upd", nupd, 0);
        chk("glitch_pontos", pontos, 2);

        // Upper saturation.
        ch = 1'b1;
        repeat (2) tick();
        ch = 1'b0;
        chk("force99", pontos, 99);
        press(3'b001, 1'b1, 8, 6, nupd);
        chk("to98", pontos, 98);
        press(3'b100, 1'b0, 8, 6, nupd);
        chk("sat_hi", pontos, 99);
        chk("sat_hi_alerta", alerta, 1);
        press(3'b001, 1'b1, 8, 6, nupd);
        chk("back98", pontos, 98);
        chk("back98_alerta", alerta, 0);

        // Lower saturation and multi-button priority.
        do_reset();
        press(3'b001, 1'b0, 8, 6, nupd);
        chk("to1", pontos, 1);
        press(3'b010, 1'b1, 8, 6, nupd);
        chk("sat_lo", pontos, 0);
        chk("sat_lo_alerta", alerta, 1);
        press(3'b101, 1'b0, 8, 6, nupd);
        chk("prio3", pontos, 3);
        chk("prio3_alerta", alerta, 0);

        // Override input.
        press(3'b010, 1'b0, 8, 6, nupd);
        chk("to5", pontos, 5);
        ch = 1'b1;
        repeat (2) tick();
        ch = 1'b0;
        chk("ch_pontos", pontos, 99);
        chk("ch_alerta", alerta, 0);
        ch = 1'b1;
        press(3'b001, 1'b1, 8, 6, nupd);
        ch = 1'b0;
        chk("ch_discard_upd", nupd, 0);
        chk("ch_discard_pontos", pontos, 99);

        // Digit scan from reset.
        do_reset();
        for (int i = 1; i <= 64; i++) begin
            tick();
            chk("scan_seq", sclk, ((i / 16) % 2 == 1) ? 2 : 1);
        end

        // Reset in the middle of a debounce, with tens digit showing.
        press(3'b001, 1'b0, 8, 6, nupd);
        guard = 0;
        while ((m_edges % 32) != 16 && guard < 40) begin
            tick();
            guard++;
        end
        chk("scan_align", m_edges % 32, 16);
        btn = 3'b010;
        repeat (2) tick();
        chk("pre_rst_pontos", pontos, 1);
        chk("pre_rst_sclk", sclk, 2);
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 6) chk("held_after_rst", pontos, 2);
        end
        btn = 3'b000;
        repeat (6) tick();

        // Randomized segments checked every cycle by the model.
        for (int k = 0; k < 300; k++) begin
            btn   = 3'($urandom_range(0, 7));
            sinal = 1'($urandom_range(0, 1));
            ch    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) btn = 3'b000;
            repeat ($urandom_range(1, 9)) tick();
        end
        btn = 3'b000;
        ch  = 1'b0;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
